ym3438_phase_gen: RTL and testbench

// - Phase generator stage directly downstream of ym3438_detune: converts per-slot fnum/block into a base

---
 rtl/ym3438_phase_gen_pkg.sv | 20 ++
 rtl/ym3438_phase_gen_if.sv | 27 ++
 rtl/ym3438_phase_gen_ring.sv | 39 +++
 rtl/ym3438_phase_gen.sv | 124 ++++++++++++
 tb/tb_ym3438_phase_gen.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ym3438_phase_gen_pkg.sv
// Shared constants and types for the YM3438 phase generator slice.
package ym3438_phase_gen_pkg;

  localparam int SLOTS   = 24;
  localparam int PHASE_W = 20;
  localparam int OUT_W   = 10;
  localparam int FNUM_W  = 11;
  localparam int BASE_W  = 17;
  localparam int SLOT_W  = 5;

  typedef logic [SLOT_W-1:0]  slot_idx_t;
  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [BASE_W-1:0]  inc17_t;

  // Slot counter advance: 0..SLOTS-1, wrapping so it never reaches 24..31.
  function automatic slot_idx_t next_slot(slot_idx_t s);
    return (s == slot_idx_t'(SLOTS - 1)) ? slot_idx_t'(0) : s + slot_idx_t'(1);
  endfunction

endpackage

// File: rtl/ym3438_phase_gen_if.sv
// Per-slot bus between the detune stage, the phase generator and the operator stage.
interface ym3438_phase_gen_if;
  import ym3438_phase_gen_pkg::*;

  logic                c1;
  logic                c2;
  logic [FNUM_W-1:0]   fnum;
  logic [2:0]          block;
  logic                dt_sign;
  logic [4:0]          dt_value;
  logic [3:0]          mul;
  logic                pg_reset;
  logic [OUT_W-1:0]    phase_out;
  phase_t              phase_raw;
  slot_idx_t           slot_out;

  modport master (
    output c1, c2, fnum, block, dt_sign, dt_value, mul, pg_reset,
    input  phase_out, phase_raw, slot_out
  );

  modport slave (
    input  c1, c2, fnum, block, dt_sign, dt_value, mul, pg_reset,
    output phase_out, phase_raw, slot_out
  );

endinterface

// File: rtl/ym3438_phase_gen_ring.sv
// 24-entry phase storage: a shift ring whose tail is the oldest slot's phase.
module ym3438_phase_ring
  import ym3438_phase_gen_pkg::*;
(
  input  logic   clk,
  input  logic   ic_n,
  input  logic   en,
  input  phase_t din,
  output phase_t dout
);

  phase_t ring_q [SLOTS];
  phase_t ring_d [SLOTS];

  // Shift one position per slot step; the new phase enters at the head.
  always_comb begin
    ring_d = ring_q;
    if (en) begin
      ring_d[0] = din;
      for (int i = 1; i < SLOTS; i++) begin
        ring_d[i] = ring_q[i-1];
      end
    end
  end

  // Ring storage, cleared entirely by the chip reset.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      ring_q <= ring_d;
    end
  end

  assign dout = ring_q[SLOTS-1];

endmodule

// File: rtl/ym3438_phase_gen.sv
// YM3438 phase generator: fnum/block -> detuned, multiplied increment -> per-slot 20-bit phase.
module ym3438_phase_gen
  import ym3438_phase_gen_pkg::*;
(
  input  logic MCLK,
  input  logic IC,
  ym3438_phase_gen_if.slave bus
);

  logic              step_c1;
  logic              step_c2;

  logic [FNUM_W-1:0] fnum_q, fnum_d;
  logic [2:0]        block_q, block_d;
  logic              dt_sign_q, dt_sign_d;
  logic [4:0]        dt_value_q, dt_value_d;
  logic [3:0]        mul_q, mul_d;
  logic              pg_reset_q, pg_reset_d;

  inc17_t            base_q, base_d;
  inc17_t            inc17_q, inc17_d;
  phase_t            inc20_q, inc20_d;
  logic              pgr_q, pgr_d;

  phase_t            phase_raw_q, phase_raw_d;
  slot_idx_t         slot_out_q, slot_out_d;
  slot_idx_t         slot_cnt_q, slot_cnt_d;

  logic [BASE_W:0]   shifted;
  phase_t            old_phase;
  phase_t            new_phase;

  // c2 wins when both enables are high, so c1 only latches on its own.
  assign step_c1 = bus.c1 & ~bus.c2;
  assign step_c2 = bus.c2;

  // Shift into 18 bits so block 7 keeps the fnum MSB before the halving.
  assign shifted   = {7'b0, fnum_q} << block_q;
  assign new_phase = pgr_q ? phase_t'(0) : old_phase + inc20_q;

  // Input latching on c1, pipeline and accumulator advance on c2.
  always_comb begin
    fnum_d      = fnum_q;
    block_d     = block_q;
    dt_sign_d   = dt_sign_q;
    dt_value_d  = dt_value_q;
    mul_d       = mul_q;
    pg_reset_d  = pg_reset_q;
    base_d      = base_q;
    inc17_d     = inc17_q;
    inc20_d     = inc20_q;
    pgr_d       = pgr_q;
    phase_raw_d = phase_raw_q;
    slot_out_d  = slot_out_q;
    slot_cnt_d  = slot_cnt_q;

    if (step_c1) begin
      fnum_d     = bus.fnum;
      block_d    = bus.block;
      dt_sign_d  = bus.dt_sign;
      dt_value_d = bus.dt_value;
      mul_d      = bus.mul;
      pg_reset_d = bus.pg_reset;
    end

    if (step_c2) begin
      base_d      = shifted[BASE_W:1];
      inc17_d     = dt_sign_q ? base_q - inc17_t'(dt_value_q)
                              : base_q + inc17_t'(dt_value_q);
      inc20_d     = (mul_q == 4'd0) ? {4'b0, inc17_q[BASE_W-1:1]}
                                    : phase_t'({3'b0, inc17_q} * {16'b0, mul_q});
      pgr_d       = pg_reset_q;
      phase_raw_d = new_phase;
      slot_out_d  = slot_cnt_q;
      slot_cnt_d  = next_slot(slot_cnt_q);
    end
  end

  // State registers with synchronous active-low clear from IC.
  always_ff @(posedge MCLK) begin
    if (!IC) begin
      fnum_q      <= '0;
      block_q     <= '0;
      dt_sign_q   <= 1'b0;
      dt_value_q  <= '0;
      mul_q       <= '0;
      pg_reset_q  <= 1'b0;
      base_q      <= '0;
      inc17_q     <= '0;
      inc20_q     <= '0;
      pgr_q       <= 1'b0;
      phase_raw_q <= '0;
      slot_out_q  <= '0;
      slot_cnt_q  <= '0;
    end else begin
      fnum_q      <= fnum_d;
      block_q     <= block_d;
      dt_sign_q   <= dt_sign_d;
      dt_value_q  <= dt_value_d;
      mul_q       <= mul_d;
      pg_reset_q  <= pg_reset_d;
      base_q      <= base_d;
      inc17_q     <= inc17_d;
      inc20_q     <= inc20_d;
      pgr_q       <= pgr_d;
      phase_raw_q <= phase_raw_d;
      slot_out_q  <= slot_out_d;
      slot_cnt_q  <= slot_cnt_d;
    end
  end

  ym3438_phase_ring u_ring (
    .clk  (MCLK),
    .ic_n (IC),
    .en   (step_c2),
    .din  (new_phase),
    .dout (old_phase)
  );

  assign bus.phase_raw = phase_raw_q;
  assign bus.phase_out = phase_raw_q[PHASE_W-1:PHASE_W-OUT_W];
  assign bus.slot_out  = slot_out_q;

endmodule

// File: tb/tb_ym3438_phase_gen.sv
// Scoreboard bench for ym3438_phase_gen: random and directed slot steps against an arithmetic model.
module tb_ym3438_phase_gen;
  import ym3438_phase_gen_pkg::*;

  logic MCLK = 1'b0;
  logic IC   = 1'b0;

  ym3438_phase_gen_if bus ();

  ym3438_phase_gen dut (
    .MCLK (MCLK),
    .IC   (IC),
    .bus  (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int raw;
    int slot;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int pass_count  = 0;
  int check_count = 0;

  // Inputs recorded by step since reset, offset by 3 so pre-reset history reads as zero.
  int h_fnum [2200];
  int h_blk  [2200];
  int h_dts  [2200];
  int h_dtv  [2200];
  int h_mul  [2200];
  int h_pgr  [2200];
  int phase_m [SLOTS];
  int step_t;

  // Directed configurations: fnum, block, dt_sign, dt_value, mul.
  int cfg [6][5] = '{
    '{'h400, 4, 0, 0, 1},
    '{'h400, 4, 0, 0, 0},
    '{'h400, 4, 0, 0, 3},
    '{'h400, 4, 1, 5, 1},
    '{'h400, 4, 0, 5, 1},
    '{'h7FF, 7, 0, 0, 15}
  };

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int model_inc(int fnum, int blk, int dts, int dtv, int mul);
    int base;
    int inc17;
    base  = (fnum << blk) >> 1;
    inc17 = dts ? ((base - dtv) & 'h1FFFF) : ((base + dtv) & 'h1FFFF);
    return (mul == 0) ? (inc17 >> 1) : ((inc17 * mul) & 'hFFFFF);
  endfunction

  task automatic model_reset();
    step_t = 0;
    for (int i = 0; i < SLOTS; i++) phase_m[i] = 0;
    for (int i = 0; i < 3; i++) begin
      h_fnum[i] = 0; h_blk[i] = 0; h_dts[i] = 0;
      h_dtv[i]  = 0; h_mul[i] = 0; h_pgr[i] = 0;
    end
    exp_q.delete();
  endtask

  // One slot step: record inputs, predict this step's output, then drive c1 and c2 edges.
  task automatic applyStimulus(input int fnum, input int blk, input int dts,
                               input int dtv, input int mul, input int pgr);
    int h;
    int slot;
    int inc;
    int newp;
    h = step_t + 3;
    h_fnum[h] = fnum; h_blk[h] = blk; h_dts[h] = dts;
    h_dtv[h]  = dtv;  h_mul[h] = mul; h_pgr[h] = pgr;
    slot = step_t % SLOTS;
    inc  = model_inc(h_fnum[step_t], h_blk[step_t], h_dts[step_t+1], h_dtv[step_t+1], h_mul[step_t+2]);
    newp = h_pgr[step_t+2] ? 0 : ((phase_m[slot] + inc) & 'hFFFFF);
    phase_m[slot] = newp;
    exp_q.push_back('{newp, slot});
    step_t++;

    @(negedge MCLK);
    bus.fnum     = 11'(fnum);
    bus.block    = 3'(blk);
    bus.dt_sign  = 1'(dts);
    bus.dt_value = 5'(dtv);
    bus.mul      = 4'(mul);
    bus.pg_reset = 1'(pgr);
    bus.c1       = 1'b1;
    @(negedge MCLK);
    bus.c1 = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      bus.fnum     = 11'($urandom);
      bus.block    = 3'($urandom);
      bus.dt_value = 5'($urandom);
      bus.mul      = 4'($urandom);
      bus.pg_reset = 1'($urandom);
      @(negedge MCLK);
    end
    bus.c2 = 1'b1;
    @(negedge MCLK);
    bus.c2 = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge MCLK);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, " phase_raw"}, int'(bus.phase_raw), 0);
    checkOutput({tag, " phase_out"}, int'(bus.phase_out), 0);
    checkOutput({tag, " slot_out"},  int'(bus.slot_out),  0);
  endtask

  // Monitor: every c2 edge outside reset presents one slot result.
  always @(posedge MCLK) begin
    if (IC && bus.c2) begin
      #1;
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_output: got slot %0d, expected no output", bus.slot_out);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("phase_raw", int'(bus.phase_raw), mon_e.raw);
        checkOutput("phase_out", int'(bus.phase_out), (mon_e.raw >> 10) & 'h3FF);
        checkOutput("slot_out",  int'(bus.slot_out),  mon_e.slot);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.c1 = 1'b0; bus.c2 = 1'b0;
    bus.fnum = '0; bus.block = '0; bus.dt_sign = 1'b0;
    bus.dt_value = '0; bus.mul = '0; bus.pg_reset = 1'b0;
    IC = 1'b0;
    model_reset();
    @(negedge MCLK);
    IC = 1'b1;
    check_reset_state("reset");

    // Silent channels: two revolutions of zero phase with the slot index cycling.
    for (int k = 0; k < 48; k++) applyStimulus(0, 0, 0, 0, $urandom_range(0, 15), 0);

    // Fully random slot parameters with occasional key-on clears.
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(0, 2047), $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 31), $urandom_range(0, 15),
                    ($urandom_range(0, 15) == 0) ? 1 : 0);
    end

    // Mid-run reset taken on an edge that also carries c2.
    @(negedge MCLK);
    IC = 1'b0;
    bus.c2 = 1'b1;
    @(negedge MCLK);
    bus.c2 = 1'b0;
    IC = 1'b1;
    model_reset();
    check_reset_state("midrun_reset");

    for (int k = 0; k < 30; k++) begin
      applyStimulus($urandom_range(0, 2047), $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 31), $urandom_range(0, 15), 0);
    end

    // Directed increments, including detune both ways, mul=0 and full-scale wrap.
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 60; k++) begin
        applyStimulus(cfg[c][0], cfg[c][1], cfg[c][2], cfg[c][3], cfg[c][4],
                      (c == 0 && k == 26) ? 1 : 0);
      end
    end

    repeat (4) @(negedge MCLK);
    if (exp_q.size() != 0) begin
      check_count++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
